exec_watchdog: RTL and testbench
================================

EXEC_WATCHDOG -- requirements
Module: exec_watchdog

Interface
REQ-001 Parameter CNT_W, default 16: cycle counter and limit width.
REQ-002 Parameter STATE_W, default 5: width of monitored control-unit state.
REQ-003 Parameter DEPTH, default 16: trace FIFO entries; power of two, at least 2.
REQ-004 Parameter STALL_LIMIT, default 8: consecutive unchanged-state cycles that flag a stall; at least 2.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  run/pause of monitoring.
REQ-008 state_in  in  STATE_W  control-unit state under observation.
REQ-009 limit  in  CNT_W  cycle budget; 0 means unlimited; sampled on IDLE->RUN.
REQ-010 cycle_count  out  CNT_W  cycles spent in RUN with enable high.
REQ-011 timeout  out  1  sticky, budget exhausted.
REQ-012 stall  out  1  sticky, state frozen for STALL_LIMIT cycles.
REQ-013 done  out  1  high in DONE.
REQ-014 trace_valid  out  1  trace word available.
REQ-015 trace_ready  in  1  consumer accepts trace word.
REQ-016 trace_data  out  CNT_W+STATE_W  {cycle_count, state} of head entry.
REQ-017 trace_overflow  out  1  sticky, a trace entry was dropped.

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on enable high; DONE left only by reset.
REQ-019 In RUN with enable high, cycle_count increments by 1 per cycle and wraps modulo 2^CNT_W when limit is 0.
REQ-020 In RUN with enable low, counter, stall counter and FSM hold.
REQ-021 Timeout: limit nonzero and cycle_count equal to limit-1 on an enabled RUN cycle -> next cycle cycle_count equals limit, timeout 1, state DONE.
REQ-022 Stall: state_in equal to previous sampled state on STALL_LIMIT consecutive enabled RUN cycles -> stall 1, state DONE, next cycle.
REQ-023 Timeout and stall on the same cycle set both flags.
REQ-024 Any change of state_in clears the stall counter.
REQ-025 Trace push: in RUN, enabled cycle where state_in differs from previous sample, plus the first RUN cycle; entry is {cycle_count before increment, state_in}.
REQ-026 FIFO first-word fall-through; trace_valid equals not-empty; pop on trace_valid and trace_ready.
REQ-027 Push while full without pop: entry dropped, trace_overflow set; push and pop on same cycle while full: both succeed.
REQ-028 In DONE no pushes; draining continues.
REQ-029 Pop with empty FIFO has no effect.

Reset
REQ-030 Reset: FSM IDLE; cycle_count 0; timeout, stall, done, trace_valid, trace_overflow 0; trace_data 0; FIFO empty.
REQ-031 Reset mid-RUN or mid-drain discards all trace contents the next cycle; reset has priority over every other event.

Configuration
REQ-032 Macro EXEC_WATCHDOG_TRACE_EN defined: trace FIFO and REQ-025..REQ-029 present.
REQ-033 Macro undefined: no storage; trace_valid, trace_data, trace_overflow tied 0; trace_ready ignored; watchdog behaviour unchanged.

Structure
REQ-034 Shared package holds the FSM state enum and the trace-entry struct typedef.
REQ-035 FIFO is sub-module trace_fifo (parameters WIDTH, DEPTH; push/pop/full/empty); instantiated only under the macro.

Verification
REQ-036 limit=10, enable held, state_in toggling each cycle -> timeout 1 and done 1 with cycle_count 10; stall 0.
REQ-037 limit=0, state_in constant 5'b00011 from the first RUN cycle -> stall 1 after 8 RUN cycles; timeout 0.
REQ-038 Trace on: states 1,2,3 on cycles 0,1,2, trace_ready 0 -> three entries popped later in order {0,1},{1,2},{2,3}.
REQ-039 Trace on, DEPTH=16, 20 state changes, trace_ready 0 -> 16 entries held, trace_overflow 1; full with push and pop on the same cycle -> no overflow.
REQ-040 enable dropped 3 cycles mid-RUN -> cycle_count frozen over those 3 cycles; stall counter frozen.
REQ-041 Reset asserted in DONE with 4 entries queued -> next cycle all outputs 0 and FSM IDLE.

Source files
------------

// File: rtl/exec_watchdog_pkg.sv
// Shared types for the execution watchdog: FSM state encoding and trace-entry layout.
// The entry struct uses the default widths, matching the {cycle_count, state} word.
package exec_watchdog_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } wd_state_e;

  localparam int unsigned TraceCntW   = 16;
  localparam int unsigned TraceStateW = 5;

  typedef struct packed {
    logic [TraceCntW-1:0]   cnt;
    logic [TraceStateW-1:0] state;
  } trace_entry_t;

endpackage

// File: rtl/exec_watchdog_trace_fifo.sv
// First-word fall-through trace FIFO; pointers carry one extra wrap bit for full/empty.
// Storage is not reset: clearing the pointers is enough to discard the contents.
module trace_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW:0]    wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);

  // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + (PtrW+1)'(do_push);
    rd_d    = rd_q + (PtrW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[PtrW-1:0]] <= push_data;
    end
  end

  assign pop_data = empty ? '0 : mem_q[rd_q[PtrW-1:0]];

endmodule

// File: rtl/exec_watchdog.sv
// Control-unit watchdog: cycle budget, stall detection and optional state-change trace.
// Define EXEC_WATCHDOG_TRACE_EN to build the trace FIFO; otherwise trace outputs are tied 0.
module exec_watchdog
  import exec_watchdog_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STATE_W     = 5,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [STATE_W-1:0]       state_in,
  input  logic [CNT_W-1:0]         limit,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     timeout,
  output logic                     stall,
  output logic                     done,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [CNT_W+STATE_W-1:0] trace_data,
  output logic                     trace_overflow
);

  localparam int unsigned StallW = $clog2(STALL_LIMIT);

  wd_state_e          st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, limit_q, limit_d;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic [StallW-1:0]  stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d, stall_q, stall_d, first_q, first_d;
  logic               run_en, changed, push;

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    prev_d      = prev_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    stall_d     = stall_q;
    first_d     = first_q;
    run_en      = (st_q == StRun) && enable;
    changed     = (state_in != prev_q);
    push        = run_en && (first_q || changed);
    unique case (st_q)
      StIdle: begin
        // The state seen on entry is the reference for the first RUN cycle's stall check.
        if (enable) begin
          st_d        = StRun;
          limit_d     = limit;
          prev_d      = state_in;
          first_d     = 1'b1;
          stall_cnt_d = '0;
        end
      end
      StRun: begin
        if (enable) begin
          cnt_d   = cnt_q + CNT_W'(1);
          prev_d  = state_in;
          first_d = 1'b0;
          stall_cnt_d = changed ? '0 : stall_cnt_q + StallW'(1);
          if ((limit_q != '0) && (cnt_q == limit_q - CNT_W'(1))) begin
            timeout_d = 1'b1;
            st_d      = StDone;
          end
          if (!changed && (stall_cnt_q == StallW'(STALL_LIMIT - 1))) begin
            stall_d = 1'b1;
            st_d    = StDone;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      limit_q     <= '0;
      prev_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
      stall_q     <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      prev_q      <= prev_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
      first_q     <= first_d;
    end
  end

  assign cycle_count = cnt_q;
  assign timeout     = timeout_q;
  assign stall       = stall_q;
  assign done        = (st_q == StDone);

`ifdef EXEC_WATCHDOG_TRACE_EN
  logic fifo_full, fifo_empty, ovf_q, ovf_d;

  trace_fifo #(
    .WIDTH(CNT_W + STATE_W),
    .DEPTH(DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({cnt_q, state_in}),
    .pop      (trace_ready),
    .pop_data (trace_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    ovf_d = ovf_q | (push && fifo_full && !trace_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign trace_valid    = !fifo_empty;
  assign trace_overflow = ovf_q;
`else
  localparam int unsigned UnusedDepth = DEPTH;
  logic unused_trace;
  assign unused_trace   = ^{trace_ready, push};
  assign trace_valid    = 1'b0;
  assign trace_data     = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_exec_watchdog.sv
// Directed bench for exec_watchdog; trace checks are active when EXEC_WATCHDOG_TRACE_EN is set.
module tb_exec_watchdog;
  import exec_watchdog_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [4:0]  state_in;
  logic [15:0] limit;
  logic [15:0] cycle_count;
  logic        timeout, stall, done;
  logic        trace_valid, trace_ready, trace_overflow;
  logic [20:0] trace_data;

  int compared = 0;
  int mismatched = 0;

  exec_watchdog #(
    .CNT_W(16),
    .STATE_W(5),
    .DEPTH(16),
    .STALL_LIMIT(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .state_in      (state_in),
    .limit         (limit),
    .cycle_count   (cycle_count),
    .timeout       (timeout),
    .stall         (stall),
    .done          (done),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_data    (trace_data),
    .trace_overflow(trace_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [20:0] entry(input logic [15:0] c, input logic [4:0] s);
    trace_entry_t e;
    e.cnt   = c;
    e.state = s;
    return e;
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    trace_ready = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; state_in = '0; limit = '0; trace_ready = 1'b0;
    tick(2);
    check("rst_count", cycle_count, 0);
    check("rst_timeout", timeout, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_valid", trace_valid, 0);
    check("rst_data", trace_data, 0);
    check("rst_ovf", trace_overflow, 0);
    reset = 1'b0;

    // Timeout: limit 10, state toggling every cycle.
    limit = 16'd10; state_in = 5'd0; enable = 1'b1;
    tick(1);
    check("to_enter_count", cycle_count, 0);
    for (int i = 0; i < 9; i++) begin
      state_in = {4'b0, ~state_in[0]};
      tick(1);
    end
    check("to_count9", cycle_count, 9);
    check("to_timeout_early", timeout, 0);
    check("to_done_early", done, 0);
    state_in = {4'b0, ~state_in[0]};
    tick(1);
    check("to_count10", cycle_count, 10);
    check("to_timeout", timeout, 1);
    check("to_done", done, 1);
    check("to_stall", stall, 0);
    state_in = {4'b0, ~state_in[0]};
    tick(2);
    check("to_done_hold", cycle_count, 10);
`ifdef EXEC_WATCHDOG_TRACE_EN
    check("to_trace_valid", trace_valid, 1);
    check("to_trace_head", trace_data, entry(16'd0, 5'd1));
`else
    check("to_trace_valid_off", trace_valid, 0);
    check("to_trace_data_off", trace_data, 0);
`endif

    // Stall: limit 0, state constant 3 from the first RUN cycle.
    do_reset();
    limit = 16'd0; state_in = 5'd3; enable = 1'b1;
    tick(1);
    tick(7);
    check("st_count7", cycle_count, 7);
    check("st_stall_early", stall, 0);
    check("st_done_early", done, 0);
    tick(1);
    check("st_stall", stall, 1);
    check("st_done", done, 1);
    check("st_timeout", timeout, 0);
    check("st_count8", cycle_count, 8);

    // Enable paused for 3 cycles mid-RUN freezes both counters.
    do_reset();
    limit = 16'd0; state_in = 5'd3; enable = 1'b1;
    tick(5);
    check("pause_count_before", cycle_count, 4);
    enable = 1'b0;
    tick(3);
    check("pause_count_frozen", cycle_count, 4);
    check("pause_done", done, 0);
    enable = 1'b1;
    tick(3);
    check("pause_count_after", cycle_count, 7);
    check("pause_stall_early", stall, 0);
    tick(1);
    check("pause_stall", stall, 1);
    check("pause_count8", cycle_count, 8);

    // Timeout and stall on the same cycle.
    do_reset();
    limit = 16'd8; state_in = 5'd3; enable = 1'b1;
    tick(9);
    check("both_timeout", timeout, 1);
    check("both_stall", stall, 1);
    check("both_count", cycle_count, 8);

`ifdef EXEC_WATCHDOG_TRACE_EN
    // Trace ordering: states 1,2,3 on cycles 0,1,2, drained afterwards.
    do_reset();
    limit = 16'd0; state_in = 5'd0; enable = 1'b1;
    tick(1);
    state_in = 5'd1; tick(1);
    state_in = 5'd2; tick(1);
    state_in = 5'd3; tick(1);
    enable = 1'b0;
    check("ord_valid", trace_valid, 1);
    check("ord_e0", trace_data, entry(16'd0, 5'd1));
    trace_ready = 1'b1;
    tick(1);
    check("ord_e1", trace_data, entry(16'd1, 5'd2));
    tick(1);
    check("ord_e2", trace_data, entry(16'd2, 5'd3));
    tick(1);
    check("ord_empty", trace_valid, 0);
    check("ord_empty_data", trace_data, 0);
    tick(1);
    check("ord_pop_empty", trace_valid, 0);
    trace_ready = 1'b0;

    // Overflow: 20 state changes into a 16-entry FIFO.
    do_reset();
    limit = 16'd0; state_in = 5'd0; enable = 1'b1;
    tick(1);
    for (int i = 1; i <= 16; i++) begin
      state_in = 5'(i);
      tick(1);
    end
    check("ovf_full_no_ovf", trace_overflow, 0);
    for (int i = 17; i <= 20; i++) begin
      state_in = 5'(i);
      tick(1);
    end
    check("ovf_set", trace_overflow, 1);
    check("ovf_head", trace_data, entry(16'd0, 5'd1));

    // Full FIFO with simultaneous push and pop: nothing dropped.
    do_reset();
    limit = 16'd0; state_in = 5'd0; enable = 1'b1;
    tick(1);
    for (int i = 1; i <= 16; i++) begin
      state_in = 5'(i);
      tick(1);
    end
    state_in = 5'd17; trace_ready = 1'b1;
    tick(1);
    trace_ready = 1'b0; enable = 1'b0;
    check("pp_no_ovf", trace_overflow, 0);
    check("pp_head", trace_data, entry(16'd1, 5'd2));
    trace_ready = 1'b1;
    tick(15);
    check("pp_last", trace_data, entry(16'd16, 5'd17));
    tick(1);
    check("pp_drained", trace_valid, 0);
    trace_ready = 1'b0;
`endif

    // Reset in DONE with 4 entries queued.
    do_reset();
    limit = 16'd4; state_in = 5'd0; enable = 1'b1;
    tick(1);
    for (int i = 1; i <= 4; i++) begin
      state_in = 5'(i);
      tick(1);
    end
    check("dr_done", done, 1);
    check("dr_count", cycle_count, 4);
`ifdef EXEC_WATCHDOG_TRACE_EN
    check("dr_valid", trace_valid, 1);
`endif
    state_in = 5'd9;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("dr_rst_count", cycle_count, 0);
    check("dr_rst_timeout", timeout, 0);
    check("dr_rst_stall", stall, 0);
    check("dr_rst_done", done, 0);
    check("dr_rst_valid", trace_valid, 0);
    check("dr_rst_data", trace_data, 0);
    check("dr_rst_ovf", trace_overflow, 0);
    reset = 1'b0; enable = 1'b0;
    tick(1);
    check("dr_idle_done", done, 0);
    check("dr_idle_count", cycle_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
